// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register: payload + control with flush, warm-up and one-shot ctrl bits.
// Latency 1 cycle (registered outputs); PIPE_SKID_EN adds a skid slot and a registered in_ready.
// Backpressure: without skid, in_ready follows out_ready combinationally; with skid, in_ready drops once two entries are held.
module pipe_stage_reg #(
    parameter int                DATA_W     = 16,
    parameter int                CTRL_W     = 8,
    parameter logic [CTRL_W-1:0] PULSE_MASK = '0,
    parameter int                WARMUP     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam logic [3:0] WARMUP_C = 4'(WARMUP);

    logic [3:0]        warm_cnt_q,   warm_cnt_d;
    logic              warm_done_q,  warm_done_d;
    logic              head_vld_q,   head_vld_d;
    logic [DATA_W-1:0] head_data_q,  head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q,  head_ctrl_d;
    logic              head_shown_q, head_shown_d;
    logic [CTRL_W-1:0] out_ctrl_q,   out_ctrl_d;
    logic [1:0]        occupancy_q,  occupancy_d;
    logic              accept;
    logic              head_take;

`ifdef PIPE_SKID_EN
    logic              skid_vld_q,  skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q,  in_ready_d;

    assign in_ready = in_ready_q;
`else
    assign in_ready = warm_done_q && (!head_vld_q || out_ready);
`endif

    assign accept    = in_valid && in_ready;
    // Head slot is free for a new entry this edge: empty, or retiring now.
    assign head_take = !head_vld_q || out_ready;

    always_comb begin
        warm_cnt_d  = (warm_cnt_q < WARMUP_C) ? warm_cnt_q + 4'd1 : warm_cnt_q;
        warm_done_d = (warm_cnt_d >= WARMUP_C);

        head_vld_d   = head_vld_q;
        head_data_d  = head_data_q;
        head_ctrl_d  = head_ctrl_q;
        head_shown_d = head_shown_q;
`ifdef PIPE_SKID_EN
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
`endif

        if (flush) begin
            head_vld_d   = 1'b0;
            head_ctrl_d  = '0;
            head_shown_d = 1'b0;
`ifdef PIPE_SKID_EN
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
`endif
        end else if (head_take) begin
            head_shown_d = 1'b0;
`ifdef PIPE_SKID_EN
            if (skid_vld_q) begin
                head_vld_d  = 1'b1;
                head_data_d = skid_data_q;
                head_ctrl_d = skid_ctrl_q;
                skid_vld_d  = 1'b0;
                skid_ctrl_d = '0;
            end else
`endif
            if (accept) begin
                head_vld_d  = 1'b1;
                head_data_d = in_data;
                head_ctrl_d = in_ctrl;
            end else begin
                head_vld_d = 1'b0;
            end
        end else begin
            // Head stalls: it has now been presented once.
            head_shown_d = 1'b1;
`ifdef PIPE_SKID_EN
            if (accept) begin
                skid_vld_d  = 1'b1;
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
            end
`endif
        end

        out_ctrl_d = head_vld_d ? (head_ctrl_d & ~(PULSE_MASK & {CTRL_W{head_shown_d}})) : '0;

`ifdef PIPE_SKID_EN
        occupancy_d = {1'b0, head_vld_d} + {1'b0, skid_vld_d};
        in_ready_d  = warm_done_d && (occupancy_d != 2'd2);
`else
        occupancy_d = {1'b0, head_vld_d};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt_q   <= '0;
            warm_done_q  <= 1'b0;
            head_vld_q   <= 1'b0;
            head_data_q  <= '0;
            head_ctrl_q  <= '0;
            head_shown_q <= 1'b0;
            out_ctrl_q   <= '0;
            occupancy_q  <= '0;
`ifdef PIPE_SKID_EN
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b0;
`endif
        end else begin
            warm_cnt_q   <= warm_cnt_d;
            warm_done_q  <= warm_done_d;
            head_vld_q   <= head_vld_d;
            head_data_q  <= head_data_d;
            head_ctrl_q  <= head_ctrl_d;
            head_shown_q <= head_shown_d;
            out_ctrl_q   <= out_ctrl_d;
            occupancy_q  <= occupancy_d;
`ifdef PIPE_SKID_EN
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign out_valid = head_vld_q;
    assign out_data  = head_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (WARMUP=2, PULSE_MASK=8'h80); skid-specific steps under PIPE_SKID_EN.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(16), .CTRL_W(8), .PULSE_MASK(8'h80), .WARMUP(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_ctrl = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_ctrl",  32'(out_ctrl),  0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_in_ready",  32'(in_ready),  0);

        // Warm-up: two edges refused, transfer on the third
        reset_n = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        tick();
        chk("wu_e1_in_ready",  32'(in_ready),  0);
        chk("wu_e1_out_valid", 32'(out_valid), 0);
        tick();
        chk("wu_e2_in_ready",  32'(in_ready),  1);
        chk("wu_e2_out_valid", 32'(out_valid), 0);
        tick();
        chk("wu_e3_out_valid", 32'(out_valid), 1);
        chk("wu_e3_out_data",  32'(out_data),  32'h1234);
        chk("wu_e3_occupancy", 32'(occupancy), 1);
        in_valid = 1'b0;

        // Streaming 1..8 back-to-back with out_ready high
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("strm_data_%0d", i), 32'(out_data),  32'(i));
            chk($sformatf("strm_vld_%0d", i),  32'(out_valid), 1);
            chk($sformatf("strm_occ_%0d", i),  32'(occupancy), 1);
            if (i == 8) in_valid = 1'b0;
            else        in_data  = 16'(i + 1);
        end
        tick();
        chk("strm_drain_vld", 32'(out_valid), 0);
        chk("strm_drain_occ", 32'(occupancy), 0);

        // Backpressure with 0xA, 0xB
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
        tick();
        chk("bp_a_data", 32'(out_data),  32'h000A);
        chk("bp_a_occ",  32'(occupancy), 1);
`ifdef PIPE_SKID_EN
        chk("bp_a_rdy",  32'(in_ready),  1);
        in_data = 16'h000B;
        tick();
        chk("bp_b_occ", 32'(occupancy), 2);
        chk("bp_b_rdy", 32'(in_ready),  0);
        in_valid = 1'b0;
        tick();
        chk("bp_hold_data", 32'(out_data),  32'h000A);
        chk("bp_hold_occ",  32'(occupancy), 2);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_data", 32'(out_data),  32'h000B);
        chk("bp_rel_occ",  32'(occupancy), 1);
        chk("bp_rel_rdy",  32'(in_ready),  1);
`else
        chk("bp_a_rdy",  32'(in_ready),  0);
        in_data = 16'h000B;
        tick();
        chk("bp_hold_data", 32'(out_data),  32'h000A);
        chk("bp_hold_occ",  32'(occupancy), 1);
        out_ready = 1'b1;
        #1;
        chk("bp_comb_rdy", 32'(in_ready), 1);
        tick();
        chk("bp_rel_data", 32'(out_data),  32'h000B);
        chk("bp_rel_occ",  32'(occupancy), 1);
        in_valid = 1'b0;
`endif
        tick();
        chk("bp_drain_vld", 32'(out_valid), 0);

        // One-shot bit 7 shown only on the first head cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00C0; in_ctrl = 8'h81;
        tick();
        chk("os_c1_ctrl", 32'(out_ctrl), 32'h81);
        in_valid = 1'b0; in_ctrl = 8'h00;
        tick();
        chk("os_c2_ctrl", 32'(out_ctrl), 32'h01);
        tick();
        chk("os_c3_ctrl", 32'(out_ctrl), 32'h01);
        chk("os_c3_data", 32'(out_data), 32'h00C0);

        // Flush beats a simultaneous accept of 0x55
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0055; in_ctrl = 8'hFF;
        #1;
        chk("fl_in_ready", 32'(in_ready), 1);
        tick();
        chk("fl_out_valid", 32'(out_valid), 0);
        chk("fl_out_ctrl",  32'(out_ctrl),  0);
        chk("fl_occ",       32'(occupancy), 0);
        chk("fl_data_hold", 32'(out_data),  32'h00C0);
        flush = 1'b0; in_valid = 1'b0; in_ctrl = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_no55_%0d", i), 32'(out_data == 16'h0055), 0);
            chk($sformatf("fl_vld_%0d", i),  32'(out_valid), 0);
        end

        // Async reset while stalled
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00D0;
        tick();
        in_data = 16'h00E0;
        tick();
`ifdef PIPE_SKID_EN
        chk("ar_pre_occ", 32'(occupancy), 2);
`else
        chk("ar_pre_occ", 32'(occupancy), 1);
`endif
        #3 reset_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_occ",       32'(occupancy), 0);
        chk("ar_in_ready",  32'(in_ready),  0);
        out_ready = 1'b1; in_data = 16'h0077;
        #1 reset_n = 1'b1;
        tick();
        chk("ar_e1_rdy", 32'(in_ready),  0);
        chk("ar_e1_vld", 32'(out_valid), 0);
        tick();
        chk("ar_e2_vld", 32'(out_valid), 0);
        tick();
        chk("ar_e3_vld",  32'(out_valid), 1);
        chk("ar_e3_data", 32'(out_data),  32'h0077);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
